// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: microcoded control sequencer for a single-bus ALU datapath.
// It runs one fetch (T0-T2, with T1W memory wait states) followed by one execute
// phase (T3-T6) chosen by the opcode in ir. All control strobes are Moore-decoded
// from the current state, plus the ir fields while in the execute states.
// The current state is exported on state_dbg so that checkers can bind to it.
//
// Handshake: start is a level request that is sampled only in IDLE; no request is
// queued while busy. mem_ready is sampled only in T1/T1W. When it is high at a
// rising edge, MDR is taken to hold the fetched word, and the sequence advances to T2.
module alu_op_sequencer #(
  parameter int DATA_W     = 32,
  parameter int REG_COUNT  = 16,
  parameter int AUTO_FETCH = 0,
  localparam int RSEL_W    = $clog2(REG_COUNT)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] ir,
  output logic              PCout,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              MDRout,
  output logic              Rout,
  output logic              MARin,
  output logic              Zin,
  output logic              PCin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              Rin,
  output logic              LOin,
  output logic              HIin,
  output logic              read,
  output logic [3:0]        ALU_operation,
  output logic [RSEL_W-1:0] reg_select,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [3:0]        state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  localparam logic [3:0] ALU_NEG   = 4'd4;
  localparam logic [3:0] ALU_NOT   = 4'd5;
  localparam logic [3:0] ALU_INCPC = 4'd13;
  localparam logic [3:0] ALU_NONE  = 4'd14;

  state_t            state_q;
  state_t            state_d;
  logic              illegal_q;
  logic [4:0]        opcode;
  logic [RSEL_W-1:0] ra;
  logic [RSEL_W-1:0] rb;
  logic [RSEL_W-1:0] rc;
  logic              op_illegal;
  logic              op_unary;
  logic              op_muldiv;
  logic [3:0]        exec_alu;
  logic              unused_ir;

  // Instruction fields: opcode on top, then Ra, Rb, Rc; the low bits are not used here.
  assign opcode    = ir[DATA_W-1 -: 5];
  assign ra        = ir[DATA_W-6 -: RSEL_W];
  assign rb        = ir[DATA_W-6-RSEL_W -: RSEL_W];
  assign rc        = ir[DATA_W-6-2*RSEL_W -: RSEL_W];
  assign unused_ir = ^ir;

  assign op_illegal = (opcode > 5'd12);
  assign op_unary   = (opcode == 5'd11) || (opcode == 5'd12);
  assign op_muldiv  = (opcode == 5'd9) || (opcode == 5'd10);

  // Opcodes 0-3 map straight to ALU codes; shifts/rotates/mul/div (4-10) skip NEG/NOT.
  always_comb begin
    exec_alu = ALU_NONE;
    if (opcode < 5'd4) exec_alu = opcode[3:0];
    else if (opcode <= 5'd10) exec_alu = 4'(opcode + 5'd2);
  end

  // Next-state selection; the ir-dependent branches are taken only from T3, T4 and T5.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = mem_ready ? S_T2 : S_T1W;
      S_T1W:   if (mem_ready) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = op_illegal ? S_DONE : S_T4;
      S_T4:    state_d = op_unary ? S_DONE : S_T5;
      S_T5:    state_d = op_muldiv ? S_T6 : S_DONE;
      S_T6:    state_d = S_DONE;
      S_DONE:  state_d = (AUTO_FETCH != 0) ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register. The illegal flag is captured at the T3 decision so that DONE does not need ir.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T3) illegal_q <= op_illegal;
    end
  end

  assign state_dbg = state_q;

  // Moore strobe decode; anything not named for a state stays low, ALU is NONE, and reg_select is 0.
  always_comb begin
    PCout         = 1'b0;
    Zlowout       = 1'b0;
    Zhighout      = 1'b0;
    MDRout        = 1'b0;
    Rout          = 1'b0;
    MARin         = 1'b0;
    Zin           = 1'b0;
    PCin          = 1'b0;
    MDRin         = 1'b0;
    IRin          = 1'b0;
    Yin           = 1'b0;
    Rin           = 1'b0;
    LOin          = 1'b0;
    HIin          = 1'b0;
    read          = 1'b0;
    ALU_operation = ALU_NONE;
    reg_select    = '0;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALU_operation = ALU_INCPC;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
      end
      // PC was already updated in T1, so the wait state only keeps the read going.
      S_T1W: begin
        read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (op_unary) begin
          Rout = 1'b1; reg_select = rb; Zin = 1'b1;
          ALU_operation = (opcode == 5'd11) ? ALU_NEG : ALU_NOT;
        end else if (!op_illegal) begin
          Rout = 1'b1; reg_select = rb; Yin = 1'b1;
        end
      end
      S_T4: begin
        if (op_unary) begin
          Zlowout = 1'b1; Rin = 1'b1; reg_select = ra;
        end else begin
          Rout = 1'b1; reg_select = rc; Zin = 1'b1; ALU_operation = exec_alu;
        end
      end
      S_T5: begin
        if (op_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else begin
          Zlowout = 1'b1; Rin = 1'b1; reg_select = ra;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
      end
      S_DONE: begin
        done = 1'b1; illegal = illegal_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: per-cycle expected strobe vectors built from the
// micro-step lists of each instruction class, plus end-to-end latency figures.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        start_af = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = '0;
  wire  [25:0] om;
  wire  [25:0] oa;
  wire  [3:0]  unused_sd_m;
  wire  [3:0]  unused_sd_a;
  int          checks = 0;
  int          errors = 0;
  logic [25:0] exp_q[$];

  // Strobe positions in the 18-bit strobe field of an observation vector.
  localparam logic [17:0] B_PCOUT = 18'h20000, B_ZLOW  = 18'h10000, B_ZHIGH = 18'h08000;
  localparam logic [17:0] B_MDROUT = 18'h04000, B_ROUT = 18'h02000, B_MARIN = 18'h01000;
  localparam logic [17:0] B_ZIN   = 18'h00800, B_PCIN  = 18'h00400, B_MDRIN = 18'h00200;
  localparam logic [17:0] B_IRIN  = 18'h00100, B_YIN   = 18'h00080, B_RIN   = 18'h00040;
  localparam logic [17:0] B_LOIN  = 18'h00020, B_HIIN  = 18'h00010, B_READ  = 18'h00008;
  localparam logic [17:0] B_BUSY  = 18'h00004, B_DONE  = 18'h00002, B_ILL   = 18'h00001;

  always #5 clock = ~clock;

  alu_op_sequencer #(.DATA_W(32), .REG_COUNT(16), .AUTO_FETCH(0)) dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(om[25]), .Zlowout(om[24]), .Zhighout(om[23]), .MDRout(om[22]), .Rout(om[21]),
    .MARin(om[20]), .Zin(om[19]), .PCin(om[18]), .MDRin(om[17]), .IRin(om[16]),
    .Yin(om[15]), .Rin(om[14]), .LOin(om[13]), .HIin(om[12]), .read(om[11]),
    .busy(om[10]), .done(om[9]), .illegal(om[8]), .ALU_operation(om[7:4]),
    .reg_select(om[3:0]), .state_dbg(unused_sd_m)
  );

  alu_op_sequencer #(.DATA_W(32), .REG_COUNT(16), .AUTO_FETCH(1)) dut_af (
    .clock(clock), .clear(clear), .start(start_af), .mem_ready(mem_ready), .ir(ir),
    .PCout(oa[25]), .Zlowout(oa[24]), .Zhighout(oa[23]), .MDRout(oa[22]), .Rout(oa[21]),
    .MARin(oa[20]), .Zin(oa[19]), .PCin(oa[18]), .MDRin(oa[17]), .IRin(oa[16]),
    .Yin(oa[15]), .Rin(oa[14]), .LOin(oa[13]), .HIin(oa[12]), .read(oa[11]),
    .busy(oa[10]), .done(oa[9]), .illegal(oa[8]), .ALU_operation(oa[7:4]),
    .reg_select(oa[3:0]), .state_dbg(unused_sd_a)
  );

  function automatic logic [25:0] mk(logic [17:0] s, logic [3:0] alu, logic [3:0] rs);
    return {s, alu, rs};
  endfunction

  // Cycles from the start edge to the done pulse, with memory answering at once.
  function automatic int latency(logic [4:0] op);
    if (op > 5'd12) return 5;
    if (op >= 5'd11) return 6;
    if (op >= 5'd9) return 8;
    return 7;
  endfunction

  task automatic check(string tag, logic [25:0] obs, logic [25:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference trace: fetch micro-steps, then the execute micro-steps of the opcode's class.
  task automatic build_expected(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                input logic [3:0] rc, input int nwait, input bit af);
    logic [3:0] alu;
    alu = (op < 5'd4) ? op[3:0] : 4'(op + 5'd2);
    exp_q.delete();
    exp_q.push_back(mk(B_PCOUT | B_MARIN | B_ZIN | B_BUSY, 4'd13, 4'd0));
    exp_q.push_back(mk(B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_BUSY, 4'd14, 4'd0));
    for (int w = 0; w < nwait; w++) exp_q.push_back(mk(B_READ | B_MDRIN | B_BUSY, 4'd14, 4'd0));
    exp_q.push_back(mk(B_MDROUT | B_IRIN | B_BUSY, 4'd14, 4'd0));
    if (op > 5'd12) begin
      exp_q.push_back(mk(B_BUSY, 4'd14, 4'd0));
    end else if (op >= 5'd11) begin
      exp_q.push_back(mk(B_ROUT | B_ZIN | B_BUSY, (op == 5'd11) ? 4'd4 : 4'd5, rb));
      exp_q.push_back(mk(B_ZLOW | B_RIN | B_BUSY, 4'd14, ra));
    end else begin
      exp_q.push_back(mk(B_ROUT | B_YIN | B_BUSY, 4'd14, rb));
      exp_q.push_back(mk(B_ROUT | B_ZIN | B_BUSY, alu, rc));
      if (op >= 5'd9) begin
        exp_q.push_back(mk(B_ZLOW | B_LOIN | B_BUSY, 4'd14, 4'd0));
        exp_q.push_back(mk(B_ZHIGH | B_HIIN | B_BUSY, 4'd14, 4'd0));
      end else begin
        exp_q.push_back(mk(B_ZLOW | B_RIN | B_BUSY, 4'd14, ra));
      end
    end
    exp_q.push_back(mk(B_DONE | B_BUSY | ((op > 5'd12) ? B_ILL : 18'h0), 4'd14, 4'd0));
    if (af) exp_q.push_back(mk(B_PCOUT | B_MARIN | B_ZIN | B_BUSY, 4'd13, 4'd0));
    else    exp_q.push_back(mk(18'h0, 4'd14, 4'd0));
  endtask

  // One instruction from IDLE; ir is garbage until T3 and start toggles randomly while busy.
  task automatic run_op(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input int nwait, input bit af, input string tag);
    logic [31:0] real_ir;
    int          n;
    int          first_done;
    real_ir    = {op, ra, rb, rc, 15'($urandom)};
    first_done = -1;
    build_expected(op, ra, rb, rc, nwait, af);
    n = exp_q.size();
    if (af) start_af = 1'b1; else start = 1'b1;
    ir        = $urandom;
    mem_ready = 1'($urandom_range(0, 1));
    for (int c = 1; c <= n; c++) begin
      @(posedge clock);
      #1;
      if (af) start_af = 1'b0;
      else    start = (c <= n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c >= 2 && c < 2 + nwait) mem_ready = 1'b0;
      else if (c == 2 + nwait)     mem_ready = 1'b1;
      else                         mem_ready = 1'($urandom_range(0, 1));
      ir = (c >= 4 + nwait) ? real_ir : $urandom;
      #1;
      check($sformatf("%s_cyc%0d", tag, c), af ? oa : om, exp_q.pop_front());
      if (first_done < 0 && (af ? oa[9] : om[9])) first_done = c;
    end
    check_int($sformatf("%s_latency", tag), first_done, latency(op) + nwait);
  endtask

  initial begin
    logic [25:0] idle_v;
    idle_v = mk(18'h0, 4'd14, 4'd0);

    // Reset: asynchronous assertion, outputs quiet, start ignored while held.
    #1 clear = 1'b0;
    #1 check("reset_main", om, idle_v);
    check("reset_af", oa, idle_v);
    start = 1'b1;
    repeat (2) @(posedge clock);
    #2 check("reset_hold", om, idle_v);
    start = 1'b0;
    clear = 1'b1;
    @(posedge clock);
    #2 check("idle_after_reset", om, idle_v);

    // Directed instructions.
    run_op(5'd2,  4'd2, 4'd5, 4'd6, 0, 1'b0, "and_r2r5r6");
    run_op(5'd1,  4'd2, 4'd5, 4'd6, 3, 1'b0, "sub_wait3");
    run_op(5'd9,  4'd1, 4'd7, 4'd3, 0, 1'b0, "mul");
    run_op(5'd11, 4'd3, 4'd4, 4'd9, 0, 1'b0, "neg");
    run_op(5'd31, 4'd8, 4'd9, 4'd10, 0, 1'b0, "illegal31");
    run_op(5'd12, 4'd15, 4'd14, 4'd0, 2, 1'b0, "not_wait2");
    run_op(5'd10, 4'd6, 4'd11, 4'd12, 1, 1'b0, "div_wait1");
    run_op(5'd13, 4'd1, 4'd1, 4'd1, 1, 1'b0, "illegal13");

    // Random instructions, legal and illegal, with random memory wait.
    for (int i = 0; i < 30; i++) begin
      run_op(5'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
             $urandom_range(0, 3), 1'b0, $sformatf("rnd%0d", i));
    end

    // Asynchronous clear in the middle of T4 with start held high.
    ir        = {5'd0, 4'd1, 4'd2, 4'd3, 15'd0};
    mem_ready = 1'b1;
    start     = 1'b1;
    repeat (5) @(posedge clock);
    #1 check("midT4_before_clear", om, mk(B_ROUT | B_ZIN | B_BUSY, 4'd0, 4'd3));
    #1 clear = 1'b0;
    #1 check("midT4_clear_async", om, idle_v);
    @(posedge clock);
    #1 check("midT4_clear_held", om, idle_v);
    #1 clear = 1'b1;
    @(posedge clock);
    #1 check("first_edge_after_clear", om, mk(B_PCOUT | B_MARIN | B_ZIN | B_BUSY, 4'd13, 4'd0));
    start = 1'b0;
    #1 clear = 1'b0;
    #1 clear = 1'b1;
    check("idle_after_second_clear", om, idle_v);

    // Auto-fetch: DONE goes straight back to T0.
    run_op(5'd0, 4'd4, 4'd5, 4'd6, 0, 1'b1, "af_add");
    #1 clear = 1'b0;
    #1 check("af_clear", oa, idle_v);
    clear = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
